// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues aligned doubleword requests, extracts and
// extends load data, builds store strobes, and stalls the front end while an access is in flight.
module mem_stage_lsu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  input  logic [4:0]       rd,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  output logic             stall,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_req_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [7:0]       dmem_wstrb,
  input  logic             dmem_resp_valid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  read_data,
  output logic [XLEN-1:0]  alu_result_d3,
  output logic [4:0]       rd_d3,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             misaligned,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        f3_q, off_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   alu_q, wdata_q;
  logic [7:0]        wstrb_q;
  logic              rw_q, m2r_q, ld_q;

  logic              is_mem, is_load, misal, issue;
  logic [2:0]        off;
  logic [XLEN-1:0]   wdata_in, rshift, ext;
  logic [7:0]        wstrb_in;

  assign is_mem  = in_valid & (mem_read | mem_write);
  assign is_load = mem_read;  // read+write together behaves as a load
  assign off     = alu_result[2:0];

  always_comb begin
    misal = 1'b0;
    case (funct3[1:0])
      2'b01:   misal = off[0];
      2'b10:   misal = |off[1:0];
      2'b11:   misal = |off;
      default: misal = 1'b0;
    endcase
  end

  assign issue    = (state == IDLE) & is_mem & ~misal;
  assign wdata_in = store_data << {off, 3'b000};

  always_comb begin
    wstrb_in = 8'h00;
    if (!is_load) begin
      case (funct3[1:0])
        2'b00:   wstrb_in = 8'h01 << off;
        2'b01:   wstrb_in = 8'h03 << off;
        2'b10:   wstrb_in = 8'h0F << off;
        default: wstrb_in = 8'hFF;
      endcase
    end
  end

  // Load data arrives as the aligned doubleword; move the addressed lane to bit 0 first.
  assign rshift = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = rshift;
    case (f3_q)
      3'b000:  ext = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
      3'b001:  ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
      3'b010:  ext = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},        rshift[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}},       rshift[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}},       rshift[31:0]};
      default: ext = rshift;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_wstrb     = 8'h00;
    read_data      = '0;
    alu_result_d3  = '0;
    rd_d3          = 5'd0;
    reg_write      = 1'b0;
    mem_to_reg     = 1'b0;
    misaligned     = 1'b0;
    case (state)
      IDLE: begin
        alu_result_d3 = alu_result;
        rd_d3         = rd;
        reg_write     = reg_write_in & in_valid;
        mem_to_reg    = mem_to_reg_in;
        if (is_mem) begin
          reg_write  = 1'b0;
          mem_to_reg = 1'b0;
          if (misal) begin
            misaligned = 1'b1;
          end else begin
            stall          = 1'b1;
            dmem_req_valid = 1'b1;
            dmem_req_we    = ~is_load;
            dmem_addr      = {alu_result[XLEN-1:3], 3'b000};
            dmem_wdata     = wdata_in;
            dmem_wstrb     = wstrb_in;
            state_nxt      = dmem_req_ready ? RESP : REQ;
          end
        end
      end
      REQ: begin
        alu_result_d3  = alu_q;
        rd_d3          = rd_q;
        stall          = 1'b1;
        dmem_req_valid = 1'b1;
        dmem_req_we    = ~ld_q;
        dmem_addr      = {alu_q[XLEN-1:3], 3'b000};
        dmem_wdata     = wdata_q;
        dmem_wstrb     = wstrb_q;
        if (dmem_req_ready) state_nxt = RESP;
      end
      RESP: begin
        alu_result_d3 = alu_q;
        rd_d3         = rd_q;
        stall         = 1'b1;
        if (dmem_resp_valid) begin
          stall      = 1'b0;
          reg_write  = rw_q;
          mem_to_reg = m2r_q;
          read_data  = ld_q ? ext : '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Hold every output quiet while reset is asserted, including the pass-through path.
    if (!rst) begin
      stall          = 1'b0;
      dmem_req_valid = 1'b0;
      dmem_req_we    = 1'b0;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      dmem_wstrb     = 8'h00;
      read_data      = '0;
      alu_result_d3  = '0;
      rd_d3          = 5'd0;
      reg_write      = 1'b0;
      mem_to_reg     = 1'b0;
      misaligned     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      f3_q    <= 3'd0;
      off_q   <= 3'd0;
      rd_q    <= 5'd0;
      alu_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= 8'h00;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        f3_q    <= funct3;
        off_q   <= off;
        rd_q    <= rd;
        alu_q   <= alu_result;
        wdata_q <= wdata_in;
        wstrb_q <= wstrb_in;
        rw_q    <= reg_write_in;
        m2r_q   <= mem_to_reg_in;
        ld_q    <= is_load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_cycles <= '0;
    else if (stall && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 64-bit RISC-V pipeline, between the EX/MEM register (upstream) and the MEM/WB register (downstream).
- Issues aligned doubleword requests to the data memory over a valid/ready request channel and a valid-only response channel.
- Extracts and sign/zero-extends load data, and generates byte strobes for stores.
- Stalls the front of the pipeline while an access is in flight; emits bubbles to MEM/WB meanwhile.

Parameters:
- XLEN, 64, datapath and address width (only 64 supported).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  load.
- mem_write  in  1  store.
- funct3  in  3  access size and signedness.
- alu_result  in  XLEN  effective address, or ALU result to pass through.
- store_data  in  XLEN  rs2 value.
- rd  in  5  destination register.
- reg_write_in  in  1  writeback enable.
- mem_to_reg_in  in  1  writeback select.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = write.
- dmem_addr  out  XLEN  {addr[63:3],3'b000}.
- dmem_wdata  out  XLEN  store data shifted to its byte lane.
- dmem_wstrb  out  8  byte enables.
- dmem_resp_valid  in  1  read data valid / write acknowledged.
- dmem_rdata  in  XLEN  aligned doubleword.
- read_data  out  XLEN  extended load result to MEM/WB.
- alu_result_d3  out  XLEN  to MEM/WB.
- rd_d3  out  5  to MEM/WB.
- reg_write  out  1  to MEM/WB.
- mem_to_reg  out  1  to MEM/WB.
- misaligned  out  1  one-cycle pulse on a misaligned access.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (rst=0, async):
  - State returns to IDLE and all latched fields clear.
  - All outputs are 0, stall_cycles is 0, any in-flight request is abandoned.
  - A dmem_resp_valid arriving after reset while in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE with no memory op (in_valid=0, or mem_read=mem_write=0):
  - Combinational pass-through: alu_result_d3=alu_result, rd_d3=rd.
  - reg_write = reg_write_in & in_valid; mem_to_reg = mem_to_reg_in.
  - read_data=0, stall=0.
- IDLE with a memory op:
  - Check alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - Misaligned: misaligned=1 for that cycle, no request, reg_write=0, stall=0; the instruction retires as a bubble.
  - Aligned: latch funct3, addr[2:0], rd, alu_result, reg_write_in, mem_to_reg_in and the op type. Assert dmem_req_valid in the same cycle; stall=1.
  - If dmem_req_ready=1 → RESP; otherwise → REQ.
- REQ: hold dmem_req_valid and all request fields stable from the latched copy; stall=1; go to RESP on dmem_req_ready.
- RESP: stall=1; wait for dmem_resp_valid.
  - In the response cycle: stall=0, reg_write and mem_to_reg from the latched copy, rd_d3 and alu_result_d3 from the latched copy.
  - read_data = extracted load data (stores: 0); next state IDLE.
- Bubbles: in any cycle with stall=1, reg_write=0 and mem_to_reg=0 so that MEM/WB captures a bubble.
- Load extraction from byte offset off=addr[2:0]:
  - 000 LB: sext of byte[off].
  - 001 LH: sext of half at off.
  - 010 LW: sext of word at off.
  - 011 LD: full doubleword.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended equivalents.
  - 111: treated as LD.
- Stores:
  - SB: wstrb = 8'b1 << off.
  - SH: wstrb = 8'b11 << off.
  - SW: wstrb = 8'hF << off.
  - SD: wstrb = 8'hFF.
  - wdata = store_data << (8*off).
- Latency: a store or load with zero-wait memory gives 1 stall cycle; result presented in the 2nd cycle. Each extra ready/response wait adds 1 cycle.
- mem_read=mem_write=1 together: treated as a load.
- stall_cycles: increments on every cycle with stall=1 and saturates at all-ones (no wrap).

Test Plan:
- Reset mid-access: load issued, rst=0 while in RESP, then resp_valid=1 in IDLE → stall=0, reg_write=0, no spurious writeback; stall_cycles=0.
- LW, addr=0x1004, rdata=0x8000_0001_0000_0000, ready=1, resp next cycle → 1 stall cycle, dmem_addr=0x1000, read_data=0xFFFF_FFFF_8000_0001, reg_write=1, rd_d3 as issued.
- LBU, addr=0x2007, rdata byte7=0xAB, ready delayed 2 cycles, resp 1 cycle after acceptance → stall=1 for 3 cycles, read_data=0x0000_0000_0000_00AB.
- SH, addr=0x3002, store_data=0x1234 → dmem_req_we=1, wstrb=8'b0000_1100, wdata=0x0000_0000_1234_0000, reg_write=0 on the response cycle.
- LD, addr=0x4004 → misaligned=1 for one cycle, dmem_req_valid=0, stall=0, reg_write=0.
- ADD pass-through: in_valid=1, reg_write_in=1, alu_result=0x55 → same-cycle alu_result_d3=0x55, reg_write=1, stall=0. Also force CNT_W=4 with 20 stall cycles → stall_cycles=15, held.
